// File: rtl/branch_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// branch_cmp_arbiter
//
// Shares one external combinational branch comparator among NUM_REQ
// requesters. A round-robin grant selects one valid requester per cycle and
// steers its funct3/operands onto the comparator ports. The comparator result
// is captured, together with the requester index and tag, into a single
// registered response slot with valid/ready backpressure.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   TAG_W    width of the opaque per-request tag
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid/ready  per-requester handshake; at most one ready bit is high
//   req_op           per-requester branch funct3, requester i at [3i+2:3i]
//   req_a, req_b     per-requester operands, requester i at [32i+31:32i]
//   req_tag          per-requester tag, requester i at [TAG_W*i +: TAG_W]
//   cmp_op/a/b       to the shared comparator (0/0/0 when idle)
//   cmp_f            comparator result, combinational from cmp_op/a/b
//   rsp_valid/ready  response slot handshake
//   rsp_id           index of the requester whose result is in the slot
//   rsp_tag          tag of that request
//   rsp_taken        captured branch-condition result
//   rsp_illegal      funct3 was not a legal branch encoding
//
// Build option:
//   BRANCH_CMP_ARB_ILLEGAL_CHK_EN  when defined, funct3 3'b010/3'b011 set
//   rsp_illegal and force rsp_taken low; when undefined rsp_illegal is 0 and
//   no decode logic exists.
// -----------------------------------------------------------------------------
module branch_cmp_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*3-1:0]       req_op,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [2:0]                 cmp_op,
    output logic [31:0]                cmp_a,
    output logic [31:0]                cmp_b,
    input  logic                       cmp_f,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_taken,
    output logic                       rsp_illegal
);

    localparam int          ID_W  = $clog2(NUM_REQ);
    localparam int unsigned NUM_U = NUM_REQ;

    // (base + off) mod NUM_REQ; both operands are below NUM_REQ, so a single
    // conditional subtraction is enough and no divider is built.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_U) begin
            sum = sum - NUM_U;
        end
        return ID_W'(sum);
    endfunction

    // Unpacked views of the flat request buses
    logic [2:0]       op_arr  [NUM_REQ];
    logic [31:0]      a_arr   [NUM_REQ];
    logic [31:0]      b_arr   [NUM_REQ];
    logic [TAG_W-1:0] tag_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i]  = req_op[3*i +: 3];
        assign a_arr[i]   = req_a[32*i +: 32];
        assign b_arr[i]   = req_b[32*i +: 32];
        assign tag_arr[i] = req_tag[TAG_W*i +: TAG_W];
    end

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;
    logic            gnt_found;
    logic            can_accept;
    logic            hs;
    logic            taken_d;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_U; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign can_accept = !rsp_valid || rsp_ready;
    assign hs         = gnt_found && can_accept;

    // The comparator sees the granted request even under backpressure; only
    // the ready strobe is gated by slot availability.
    always_comb begin
        req_ready = '0;
        cmp_op    = 3'b000;
        cmp_a     = '0;
        cmp_b     = '0;
        if (gnt_found) begin
            cmp_op = op_arr[gnt_idx];
            cmp_a  = a_arr[gnt_idx];
            cmp_b  = b_arr[gnt_idx];
        end
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef BRANCH_CMP_ARB_ILLEGAL_CHK_EN
    logic op_illegal;

    // funct3 3'b010 and 3'b011 are the only non-branch encodings
    assign op_illegal = (cmp_op[2:1] == 2'b01);
    assign taken_d    = cmp_f && !op_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_illegal <= 1'b0;
        end else if (hs) begin
            rsp_illegal <= op_illegal;
        end
    end
`else
    assign taken_d     = cmp_f;
    assign rsp_illegal = 1'b0;
`endif

    // Response slot and pointer. A drain in the same cycle as a new handshake
    // simply overwrites the slot, so rsp_valid stays high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rsp_taken <= 1'b0;
        end else if (hs) begin
            rr_ptr    <= wrap_add(gnt_idx, 1);
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_tag   <= tag_arr[gnt_idx];
            rsp_taken <= taken_d;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
`timescale 1ns/1ps
module tb_branch_cmp_arbiter;

    localparam int N  = 2;
    localparam int TW = 4;
    localparam int IW = $clog2(N);
`ifdef BRANCH_CMP_ARB_ILLEGAL_CHK_EN
    localparam bit ILL_CHK = 1'b1;
`else
    localparam bit ILL_CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*3-1:0]  req_op;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*TW-1:0] req_tag;
    logic [2:0]      cmp_op;
    logic [31:0]     cmp_a;
    logic [31:0]     cmp_b;
    logic            cmp_f;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [TW-1:0]   rsp_tag;
    logic            rsp_taken;
    logic            rsp_illegal;

    // Per-requester stimulus, packed onto the flat buses
    logic [N-1:0]  v;
    logic [2:0]    op [N];
    logic [31:0]   a  [N];
    logic [31:0]   b  [N];
    logic [TW-1:0] tg [N];

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_op[3*i +: 3]    = op[i];
        assign req_a[32*i +: 32]   = a[i];
        assign req_b[32*i +: 32]   = b[i];
        assign req_tag[TW*i +: TW] = tg[i];
    end
    assign req_valid = v;

    always #5 clk = ~clk;

    branch_cmp_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .cmp_op      (cmp_op),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_f       (cmp_f),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_tag     (rsp_tag),
        .rsp_taken   (rsp_taken),
        .rsp_illegal (rsp_illegal)
    );

    // Branch condition by funct3; non-branch encodings return 1 so that the
    // illegal-op masking is observable.
    function automatic logic br_cond(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return $signed(x) <  $signed(y);
            3'b101:  return $signed(x) >= $signed(y);
            3'b110:  return x <  y;
            3'b111:  return x >= y;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic is_ill(input logic [2:0] f);
        return ILL_CHK && (f == 3'b010 || f == 3'b011);
    endfunction

    function automatic logic exp_taken(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return is_ill(f) ? 1'b0 : br_cond(f, x, y);
    endfunction

    // Stand-in for the external comparator
    assign cmp_f = br_cond(cmp_op, cmp_a, cmp_b);

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        v = '0;
        for (int i = 0; i < N; i++) begin
            op[i] = 3'b000;
            a[i]  = '0;
            b[i]  = '0;
            tg[i] = '0;
        end
    endtask

    typedef struct {
        logic [IW-1:0] rq;
        logic [2:0]    f;
        logic [31:0]   x;
        logic [31:0]   y;
        logic [TW-1:0] t;
        logic          tk;
        logic          ill;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    // Reference model state for the random phase
    int            m_ptr;
    logic          m_valid;
    int            m_id;
    logic [TW-1:0] m_tag;
    logic          m_taken;
    logic          m_ill;
    int            g;
    logic          can;
    logic [N-1:0]  exp_rdy;
    logic [2:0]    e_op;
    logic [31:0]   e_a;
    logic [31:0]   e_b;

    initial begin
        tbl[0]  = '{1'd0, 3'b001, 32'd5,          32'd7,          4'h3, 1'b1, 1'b0};
        tbl[1]  = '{1'd0, 3'b100, 32'hFFFF_FFFF,  32'd1,          4'h4, 1'b1, 1'b0};
        tbl[2]  = '{1'd0, 3'b110, 32'hFFFF_FFFF,  32'd1,          4'h5, 1'b0, 1'b0};
        tbl[3]  = '{1'd1, 3'b000, 32'd1234,       32'd1234,       4'h6, 1'b1, 1'b0};
        tbl[4]  = '{1'd1, 3'b000, 32'd1234,       32'd1235,       4'h7, 1'b0, 1'b0};
        tbl[5]  = '{1'd0, 3'b101, 32'h8000_0000,  32'h7FFF_FFFF,  4'h8, 1'b0, 1'b0};
        tbl[6]  = '{1'd1, 3'b111, 32'h8000_0000,  32'h7FFF_FFFF,  4'h9, 1'b1, 1'b0};
        tbl[7]  = '{1'd1, 3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'hA, 1'b1, 1'b0};
        tbl[8]  = '{1'd0, 3'b110, 32'd0,          32'd0,          4'hB, 1'b0, 1'b0};
        tbl[9]  = '{1'd1, 3'b010, 32'd0,          32'd0,          4'hC, !ILL_CHK, ILL_CHK};
        tbl[10] = '{1'd0, 3'b011, 32'd5,          32'd5,          4'hD, !ILL_CHK, ILL_CHK};

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        clear_inputs();
        #12;
        check("rst_rsp_valid",   rsp_valid,   0);
        check("rst_rsp_id",      rsp_id,      0);
        check("rst_rsp_tag",     rsp_tag,     0);
        check("rst_rsp_taken",   rsp_taken,   0);
        check("rst_rsp_illegal", rsp_illegal, 0);
        check("rst_req_ready",   req_ready,   0);
        check("rst_cmp_op",      cmp_op,      0);
        check("rst_cmp_a",       cmp_a,       0);
        rst_n = 1'b1;
        tick();

        // ---------------- table-driven single requests ----------------
        rsp_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            clear_inputs();
            op[tbl[k].rq] = tbl[k].f;
            a[tbl[k].rq]  = tbl[k].x;
            b[tbl[k].rq]  = tbl[k].y;
            tg[tbl[k].rq] = tbl[k].t;
            v[tbl[k].rq]  = 1'b1;
            #2;
            check("tbl_req_ready", req_ready, N'(1) << tbl[k].rq);
            check("tbl_cmp_op",    cmp_op,    tbl[k].f);
            check("tbl_cmp_a",     cmp_a,     tbl[k].x);
            check("tbl_cmp_b",     cmp_b,     tbl[k].y);
            tick();
            v = '0;
            check("tbl_rsp_valid",   rsp_valid,   1);
            check("tbl_rsp_id",      rsp_id,      tbl[k].rq);
            check("tbl_rsp_tag",     rsp_tag,     tbl[k].t);
            check("tbl_rsp_taken",   rsp_taken,   tbl[k].tk);
            check("tbl_rsp_illegal", rsp_illegal, tbl[k].ill);
        end
        tick();
        check("drain_rsp_valid", rsp_valid, 0);

        // ---------------- backpressure ----------------
        clear_inputs();
        rsp_ready = 1'b0;
        op[0] = 3'b001; a[0] = 32'd1; b[0] = 32'd2; tg[0] = 4'h9; v[0] = 1'b1;
        #2;
        check("bp_load_ready", req_ready, 2'b01);
        tick();
        clear_inputs();
        op[1] = 3'b000; a[1] = 32'd3; b[1] = 32'd3; tg[1] = 4'hA; v[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("bp_req_ready", req_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id",    rsp_id,    0);
            check("bp_rsp_tag",   rsp_tag,   4'h9);
            check("bp_rsp_taken", rsp_taken, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #2;
        check("bp_release_ready", req_ready, 2'b10);
        tick();
        v = '0;
        check("bp_next_valid", rsp_valid, 1);
        check("bp_next_id",    rsp_id,    1);
        check("bp_next_tag",   rsp_tag,   4'hA);
        check("bp_next_taken", rsp_taken, 1);
        tick();
        check("bp_drain_valid", rsp_valid, 0);

        // ---------------- asynchronous reset mid-operation ----------------
        clear_inputs();
        rsp_ready = 1'b0;
        op[1] = 3'b001; a[1] = 32'd1; b[1] = 32'd2; tg[1] = 4'hF; v[1] = 1'b1;
        tick();
        v = '0;
        check("ar_pre_valid", rsp_valid, 1);
        check("ar_pre_ptr",   dut.rr_ptr, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rsp_valid",   rsp_valid,   0);
        check("ar_rsp_id",      rsp_id,      0);
        check("ar_rsp_tag",     rsp_tag,     0);
        check("ar_rsp_taken",   rsp_taken,   0);
        check("ar_rsp_illegal", rsp_illegal, 0);
        check("ar_req_ready",   req_ready,   0);
        check("ar_rr_ptr",      dut.rr_ptr,  0);
        #3;
        rst_n = 1'b1;
        tick();

        // ---------------- round robin after reset ----------------
        rsp_ready = 1'b1;
        op[0] = 3'b000; a[0] = 32'd7; b[0] = 32'd7; tg[0] = 4'h1;
        op[1] = 3'b001; a[1] = 32'd7; b[1] = 32'd7; tg[1] = 4'h2;
        v = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("rr_req_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_rsp_id",    rsp_id,     k % 2);
            check("rr_rsp_tag",   rsp_tag,    (k % 2 == 0) ? 4'h1 : 4'h2);
            check("rr_rsp_taken", rsp_taken,  (k % 2 == 0) ? 1 : 0);
            check("rr_ptr",       dut.rr_ptr, (k + 1) % 2);
        end
        v = '0;
        tick();

        // ---------------- randomized against reference model ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        clear_inputs();
        tick();
        m_ptr = 0; m_valid = 1'b0; m_id = 0; m_tag = '0; m_taken = 1'b0; m_ill = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // requesters hold valid and payload until accepted
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i]  = 1'b1;
                    op[i] = 3'($urandom_range(0, 7));
                    a[i]  = $urandom;
                    b[i]  = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
                    tg[i] = TW'($urandom_range(0, 15));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);

            g = -1;
            for (int off = 0; off < N; off++) begin
                if (g < 0 && v[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
            can     = !m_valid || rsp_ready;
            exp_rdy = (g >= 0 && can) ? (N'(1) << g) : '0;
            e_op = 3'b000; e_a = '0; e_b = '0;
            if (g >= 0) begin
                e_op = op[g]; e_a = a[g]; e_b = b[g];
            end
            #2;
            check("rnd_req_ready",   req_ready,   exp_rdy);
            check("rnd_cmp_op",      cmp_op,      e_op);
            check("rnd_cmp_a",       cmp_a,       e_a);
            check("rnd_cmp_b",       cmp_b,       e_b);
            check("rnd_rsp_valid",   rsp_valid,   m_valid);
            check("rnd_rsp_id",      rsp_id,      m_id);
            check("rnd_rsp_tag",     rsp_tag,     m_tag);
            check("rnd_rsp_taken",   rsp_taken,   m_taken);
            check("rnd_rsp_illegal", rsp_illegal, m_ill);
            tick();
            if (g >= 0 && can) begin
                m_valid = 1'b1;
                m_id    = g;
                m_tag   = tg[g];
                m_taken = exp_taken(op[g], a[g], b[g]);
                m_ill   = is_ill(op[g]);
                m_ptr   = (g + 1) % N;
                v[g]    = 1'b0;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
